// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the keypad event queue.
//   KEY_NONE / KEY_0..KEY_6 : scanner codes (active-low one-of-seven, 4'b1111 = no key)
//   key_state_t             : debounce FSM states
//   is_key()                : true for a legal key code (4'b1000..4'b1110)
package key_pkg;

  localparam logic [3:0] KEY_NONE = 4'b1111;
  localparam logic [3:0] KEY_0    = 4'b1110;
  localparam logic [3:0] KEY_1    = 4'b1101;
  localparam logic [3:0] KEY_2    = 4'b1100;
  localparam logic [3:0] KEY_3    = 4'b1011;
  localparam logic [3:0] KEY_4    = 4'b1010;
  localparam logic [3:0] KEY_5    = 4'b1001;
  localparam logic [3:0] KEY_6    = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAND = 2'd1,
    HELD = 2'd2
  } key_state_t;

  // Codes below 4'b1000 never come from a healthy scanner; they are
  // folded into "idle" so glitches cannot create phantom keys.
  function automatic logic is_key(input logic [3:0] code);
    return code[3] && (code != KEY_NONE);
  endfunction

endpackage

// File: rtl/key_fifo.sv
// key_fifo: small event FIFO (4-bit entries) between the debouncer and the consumer.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : enqueue request from the debouncer
//   pop             : consumer ready; an entry leaves when pop && head_valid
//   head_valid      : FIFO holds at least one entry
//   head_data       : oldest entry, KEY_NONE when empty
//   count           : number of stored entries
//   overflow        : one-cycle pulse when a push is dropped because the FIFO is full
// Handshake: an entry transfers on any cycle where head_valid && pop; head_valid
// and head_data hold steady while pop is low.
module key_fifo
  import key_pkg::*;
#(
  parameter int DEPTH = 4  // power of two, at least 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [3:0]               push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [3:0]               head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      overflow <= push && !do_push;
    end
  end

  // Storage needs no reset: the head is masked by the empty flag.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_valid = !empty;
  assign head_data  = empty ? KEY_NONE : mem[rd_ptr];
  assign count      = count_q;

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: turns the scanner's scan-modulated code into one debounced
// event per key press and buffers events for the vending-machine controller.
//   clk, rst    : clock, synchronous active-high reset
//   btn_pres    : scanner code, 4'b1111 = no key
//   key_valid   : an event is waiting at the FIFO head
//   key_code    : head event code, 4'b1111 when key_valid is low
//   key_ready   : consumer accepts the head when key_valid && key_ready
//   fifo_count  : stored events
//   overflow    : one-cycle pulse when an event is dropped (FIFO full)
//   dbg_state   : debounce FSM state
module key_event_queue
  import key_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,  // at least 2
  parameter int GAP_CYCLES = 8,      // at least 4 (one scanner sweep)
  parameter int DEPTH      = 4       // power of two
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             btn_pres,
  output logic                   key_valid,
  output logic [3:0]             key_code,
  input  logic                   key_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output key_state_t             dbg_state
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int SW = $clog2(DEB_CYCLES);
  localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_CYCLES);
  // stab counts from 0 on the first candidate cycle; the push happens on the
  // cycle whose increment would reach DEB_CYCLES-1, so the key has then been
  // seen for DEB_CYCLES consecutive tracker samples.
  localparam logic [SW-1:0] STAB_LAST = SW'(DEB_CYCLES - 2);

  // Presence tracker: bridges the idle samples the scanner emits while it
  // sweeps the other columns.
  logic [GW-1:0] gap_q;
  logic [3:0]    seen_code;
  logic          present;

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q     <= GAP_MAX;
      seen_code <= KEY_NONE;
    end else if (is_key(btn_pres)) begin
      gap_q     <= '0;
      seen_code <= btn_pres;
    end else if (gap_q != GAP_MAX) begin
      gap_q     <= gap_q + 1'b1;
    end
  end

  assign present = (gap_q < GAP_MAX);

  // Debounce FSM
  key_state_t    state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [SW-1:0] stab_q, stab_d;
  logic          push;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= KEY_NONE;
      stab_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    stab_d  = stab_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (present) begin
          state_d = CAND;
          cand_d  = seen_code;
          stab_d  = '0;
        end
      end
      CAND: begin
        if (!present) begin
          state_d = IDLE;
        end else if (seen_code != cand_q) begin
          cand_d = seen_code;
          stab_d = '0;
        end else if (stab_q == STAB_LAST) begin
          push    = 1'b1;
          state_d = HELD;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      HELD: begin
        // Code changes while held are ignored until the key is released.
        if (!present) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state = state_q;

  key_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (cand_q),
    .pop        (key_ready),
    .head_valid (key_valid),
    .head_data  (key_code),
    .count      (fifo_count),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_key_event_queue.sv
module tb_key_event_queue;
  import key_pkg::*;

  localparam int DEB   = 4;
  localparam int GAP   = 4;
  localparam int DEPTH = 4;

  // clock / reset / DUT
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_pres = KEY_NONE;
  logic       key_ready = 1'b0;
  logic       key_valid;
  logic [3:0] key_code;
  logic [2:0] fifo_count;
  logic       overflow;
  key_state_t dbg_state;

  always #5 clk = ~clk;

  key_event_queue #(
    .DEB_CYCLES(DEB),
    .GAP_CYCLES(GAP),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_pres   (btn_pres),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  int valid_hits = 0;
  int ovf_hits = 0;
  logic [3:0] last_code = KEY_NONE;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a key yields one event once it has been present with one
  // code for DEB consecutive samples since its last release; presence means
  // fewer than GAP idle samples since the last legal code.
  int         m_since;
  logic [3:0] m_seen;
  logic [3:0] m_prev_seen;
  logic       m_prev_pres;
  logic       m_armed;
  int         m_run;
  logic       m_ovf;
  logic [3:0] exp_q[$];

  task automatic model_reset();
    m_since     = GAP;
    m_seen      = KEY_NONE;
    m_prev_seen = KEY_NONE;
    m_prev_pres = 1'b0;
    m_armed     = 1'b1;
    m_run       = 0;
    m_ovf       = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [3:0] b, input logic r);
    logic pres, ev, pop_now;
    pres = (m_since < GAP);
    if (pres) m_run = (m_prev_pres && m_seen == m_prev_seen) ? m_run + 1 : 1;
    else begin
      m_run   = 0;
      m_armed = 1'b1;
    end
    ev = pres && m_armed && (m_run == DEB);
    if (ev) m_armed = 1'b0;
    m_prev_pres = pres;
    m_prev_seen = m_seen;
    pop_now = r && (exp_q.size() > 0);
    m_ovf   = ev && (exp_q.size() == DEPTH) && !pop_now;
    if (pop_now) void'(exp_q.pop_front());
    if (ev && !m_ovf) exp_q.push_back(m_seen);
    if (b[3] && b != KEY_NONE) begin
      m_seen  = b;
      m_since = 0;
    end else if (m_since < GAP) begin
      m_since++;
    end
  endtask

  task automatic compare_model();
    logic [3:0] exp_code;
    exp_code = KEY_NONE;
    if (exp_q.size() > 0) exp_code = exp_q[0];
    chk("valid", key_valid, exp_q.size() > 0);
    chk("code", key_code, exp_code);
    chk("count", fifo_count, exp_q.size());
    chk("overflow", overflow, m_ovf);
    if (key_valid) begin
      valid_hits++;
      last_code = key_code;
    end
    if (overflow) ovf_hits++;
  endtask

  // driver tasks
  task automatic step(input logic [3:0] b, input logic r);
    btn_pres  = b;
    key_ready = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    compare_model();
  endtask

  task automatic do_reset(input logic [3:0] b);
    btn_pres = b;
    rst      = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    compare_model();
    chk("rst_state", dbg_state, IDLE);
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int idle, input logic r);
    repeat (hold) step(code, r);
    repeat (idle) step(KEY_NONE, r);
  endtask

  // table for the flickering press
  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    logic       exp_valid;
    logic [3:0] exp_code;
    logic [2:0] exp_count;
  } vec_t;

  vec_t vecs[24];

  initial begin
    logic [3:0] order [4];

    for (int i = 0; i < 24; i++) begin
      vecs[i].btn       = (i < 20 && (i % 4) < 2) ? KEY_1 : KEY_NONE;
      vecs[i].rdy       = 1'b1;
      vecs[i].exp_valid = (i == 4);
      vecs[i].exp_code  = (i == 4) ? KEY_1 : KEY_NONE;
      vecs[i].exp_count = (i == 4) ? 3'd1 : 3'd0;
    end

    do_reset(KEY_NONE);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, KEY_NONE);
    chk("rst_count", fifo_count, 0);

    // Flickering press: one event, visible on the fifth sample.
    valid_hits = 0;
    for (int i = 0; i < 24; i++) begin
      step(vecs[i].btn, vecs[i].rdy);
      chk("tbl_valid", key_valid, vecs[i].exp_valid);
      chk("tbl_code", key_code, vecs[i].exp_code);
      chk("tbl_count", fifo_count, vecs[i].exp_count);
    end
    chk("flicker_events", valid_hits, 1);

    // Short burst, gap, then a steady press (model-checked every cycle).
    press(KEY_0, 2, 5, 1'b1);
    press(KEY_0, 10, 6, 1'b1);

    // Code change while still a candidate.
    valid_hits = 0;
    press(KEY_3, 2, 0, 1'b1);
    press(KEY_4, 10, 6, 1'b1);
    chk("change_events", valid_hits, 1);
    chk("change_code", last_code, KEY_4);

    // Long hold, release after GAP idle samples, second press.
    valid_hits = 0;
    press(KEY_6, 50, 4, 1'b1);
    press(KEY_2, 8, 6, 1'b1);
    chk("hold_events", valid_hits, 2);

    // Consumer stalled: six presses into a four-entry FIFO.
    ovf_hits = 0;
    press(KEY_0, 6, 6, 1'b0);
    press(KEY_1, 6, 6, 1'b0);
    press(KEY_2, 6, 6, 1'b0);
    press(KEY_3, 6, 6, 1'b0);
    press(KEY_4, 6, 6, 1'b0);
    press(KEY_5, 6, 6, 1'b0);
    chk("full_count", fifo_count, 4);
    chk("ovf_pulses", ovf_hits, 2);
    order[0] = KEY_0;
    order[1] = KEY_1;
    order[2] = KEY_2;
    order[3] = KEY_3;
    chk("drain_head0", key_code, order[0]);
    for (int i = 1; i < 4; i++) begin
      step(KEY_NONE, 1'b1);
      chk("drain_valid", key_valid, 1);
      chk("drain_head", key_code, order[i]);
    end
    step(KEY_NONE, 1'b1);
    chk("drain_empty", key_valid, 0);

    // Reset with three queued events and a candidate in progress.
    press(KEY_0, 6, 6, 1'b0);
    press(KEY_1, 6, 6, 1'b0);
    press(KEY_2, 6, 6, 1'b0);
    step(KEY_6, 1'b0);
    step(KEY_6, 1'b0);
    chk("pre_rst_state", dbg_state, CAND);
    chk("pre_rst_count", fifo_count, 3);
    do_reset(KEY_6);
    chk("post_rst_valid", key_valid, 0);
    chk("post_rst_code", key_code, KEY_NONE);
    chk("post_rst_count", fifo_count, 0);
    for (int k = 1; k <= 5; k++) begin
      step(KEY_6, 1'b0);
      chk("redebounce_count", fifo_count, (k == 5) ? 1 : 0);
    end
    press(KEY_NONE, 0, 6, 1'b1);

    // Randomized traffic against the model.
    for (int seg = 0; seg < 250; seg++) begin
      int         sel;
      int         hold;
      logic [3:0] code;
      logic       rdy;
      sel  = $urandom_range(0, 9);
      hold = $urandom_range(1, 10);
      if (sel <= 6)      code = 4'(14 - sel);
      else if (sel == 7) code = KEY_NONE;
      else if (sel == 8) code = 4'($urandom_range(0, 7));
      else               code = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) do_reset(KEY_NONE);
      for (int c = 0; c < hold; c++) begin
        rdy = ($urandom_range(0, 3) != 0);
        step(($urandom_range(0, 3) == 0) ? KEY_NONE : code, rdy);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
# key_event_queue

Sits directly downstream of the 4x4 keypad scanner. It turns the scanner's raw, scan-modulated `btn_pres` code into exactly one debounced event per physical key press. Events are buffered in a small FIFO and handed to the vending-machine control FSM over a valid/ready handshake. It absorbs the scanner's per-column idle flicker, contact bounce and any stall of the consumer.

## Interface
- `DEB_CYCLES`, default 50000: consecutive cycles a key must stay present with an unchanged code before an event is generated. Minimum 2.
- `GAP_CYCLES`, default 8: idle (`4'b1111`) samples tolerated before a key counts as released. Must be at least 4 to bridge one scanner sweep.
- `DEPTH`, default 4: FIFO entries, a power of two.
- `clk` in 1: system clock, same as the scanner.
- `rst` in 1: synchronous, active-high reset.
- `btn_pres` in 4: scanner code. `4'b1111` means none; `4'b1110`..`4'b1000` are keys 0..6.
- `key_valid` out 1: FIFO head holds an event.
- `key_code` out 4: event code (scanner encoding). Equals `4'b1111` when `key_valid` is 0.
- `key_ready` in 1: consumer accepts the head when `key_valid` && `key_ready`.
- `fifo_count` out $clog2(DEPTH)+1: number of stored events.
- `overflow` out 1: one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- Presence tracker, registered:
  - Any non-`4'b1111` sample loads `seen_code` and clears `gap`.
  - An idle sample increments `gap`, saturating at `GAP_CYCLES`.
  - `present` = (`gap` < `GAP_CYCLES`).
  - Any code outside `4'b1000`..`4'b1111` is treated as idle.
- FSM states: IDLE, CAND, HELD.
  - IDLE: `present` → CAND, `cand` <= `seen_code`, `stab` <= 0.
  - CAND, `!present` → IDLE with no event.
  - CAND, `seen_code` != `cand` → stay in CAND, `cand` <= `seen_code`, `stab` <= 0.
  - CAND otherwise: `stab`++. On `stab` == `DEB_CYCLES`-1, push `cand` and go to HELD.
  - HELD: `!present` → IDLE. A code change while held is ignored; no second event until release.
- FIFO:
  - Push from the FSM; pop on `key_valid` && `key_ready`.
  - Full with a push and no pop: the new event is dropped, `overflow` pulses, contents are unchanged.
  - Full with simultaneous push and pop: both take effect, count unchanged, no overflow.
  - Empty with a push: the entry appears at the head on the next cycle; no bypass.
  - Read and write pointers wrap modulo `DEPTH`.
- Reset:
  - State IDLE, `gap` = `GAP_CYCLES` (absent), `stab` = 0.
  - FIFO empty; `key_valid` = 0, `key_code` = `4'b1111`, `fifo_count` = 0, `overflow` = 0.
  - Reset mid-press discards the pending candidate and all queued events. A key still held after reset must pass through the full debounce again.

## Timing
- All outputs are registered or decoded from registers; there is no combinational path from `btn_pres` to any output.
- Sample first non-idle code at cycle 0, key held with flicker shorter than `GAP_CYCLES`:
  - state = CAND at cycle 1;
  - push at cycle `DEB_CYCLES`;
  - `key_valid` = 1 at cycle `DEB_CYCLES`+1.
- Release is recognised `GAP_CYCLES` cycles after the last non-idle sample.
- The FIFO head updates the cycle after a pop; the next entry is presented with no bubble.
- `key_valid` and `key_code` stay stable while `key_ready` = 0.
- Sustained throughput is one pop per cycle.

## Structure
- Package `key_pkg`:
  - `KEY_NONE` = `4'b1111`;
  - `KEY_0`..`KEY_6` codes;
  - FSM state typedef {IDLE, CAND, HELD}.
- Sub-module `key_fifo` (parameter `DEPTH`, width 4): push/pop/full/empty/count, plus the drop-on-full rule.
- Top module holds the presence tracker, the counters and the FSM.

## Test plan
All scenarios use `DEB_CYCLES`=4, `GAP_CYCLES`=4, `DEPTH`=4.
1. Drive `4'b1101` for 2 cycles out of every 4 for 20 cycles, `key_ready`=1 → exactly one `key_valid` pulse with `key_code`=`4'b1101`, first asserted at cycle 5.
2. Bounce: `4'b1110` for 2 cycles, idle for 5, then `4'b1110` steady → no event from the first burst; one event 5 cycles after the steady start.
3. Code change in CAND: `4'b1011` for 2 cycles, then `4'b1010` steady → single event `4'b1010`.
4. Hold `4'b1000` for 50 cycles, then idle → one event only; a new press after 4 idle cycles produces a second event.
5. `key_ready`=0, six distinct presses → `fifo_count`=4, `overflow` pulses twice. Then `key_ready`=1 → the first four codes come out in order on consecutive cycles.
6. Assert `rst` for 1 cycle while `fifo_count`=3 and a key is in CAND → next cycle `key_valid`=0, `key_code`=`4'b1111`, `fifo_count`=0; the held key re-emits only after a full debounce.
